// File: rtl/counter_seq_pkg.sv
// rtl/counter_seq_pkg.sv - shared types and constants for the counter sequencer
//
// Contents:
//   CNT_W   default counter width
//   op_e    command opcodes carried on cmd_op
//   state_e sequencer FSM states
package counter_seq_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_RUN_N  = 2'd1,
    OP_RUN_TO = 2'd2,
    OP_CLEAR  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN_N  = 3'd2,
    ST_RUN_TO = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/counter_seq_remain.sv
// rtl/counter_seq_remain.sv - loadable down-counter with zero/one detect for RUN_N
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (clears the count)
//   load          capture load_value (has priority over dec)
//   load_value    W-bit value to capture
//   dec           decrement by one (caller guarantees count is nonzero)
//   is_zero       count == 0
//   is_one        count == 1
module counter_seq_remain
  import counter_seq_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         is_zero,
  output logic         is_one
);

  logic [W-1:0] remain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain <= '0;
    end else if (load) begin
      remain <= load_value;
    end else if (dec) begin
      remain <= remain - W'(1);
    end
  end

  assign is_zero = (remain == '0);
  assign is_one  = (remain == W'(1));

endmodule

// File: rtl/counter_seq.sv
// rtl/counter_seq.sv - command sequencer driving an external loadable up-counter
//
// Optional feature macro: COUNTER_SEQ_ABORT_EN (adds abort input, aborted output)
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cmd_valid    command offered
//   cmd_ready    high in IDLE; command accepted on cmd_valid && cmd_ready
//   cmd_op       LOAD / RUN_N / RUN_TO / CLEAR
//   cmd_data     load value, cycle count or target value
//   hold         stalls counting (not loads)
//   cnt_value    counter's current count
//   cnt_load     counter load strobe
//   cnt_enable   counter count-enable
//   cnt_data     counter data_in (zero outside LOAD)
//   busy         a command is in progress
//   done         one-cycle completion pulse
//   abort        (feature) end a RUN_N/RUN_TO command early
//   aborted      (feature) high with done when the command was aborted
module counter_seq
  import counter_seq_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_data,
  input  logic         hold,
  input  logic [W-1:0] cnt_value,
  output logic         cnt_load,
  output logic         cnt_enable,
  output logic [W-1:0] cnt_data,
  output logic         busy,
  output logic         done
`ifdef COUNTER_SEQ_ABORT_EN
  ,
  input  logic         abort,
  output logic         aborted
`endif
);

  state_e       state;
  logic [W-1:0] op_data;
  logic         accept;
  logic         abort_w;
  logic         rem_zero;
  logic         rem_one;
  logic         rem_dec;
  logic         at_target;

`ifdef COUNTER_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign accept    = (state == ST_IDLE) && cmd_valid;
  assign at_target = (cnt_value == op_data);

  // One decrement per issued enable; N=0 never decrements.
  assign rem_dec = (state == ST_RUN_N) && !hold && !rem_zero && !abort_w;

  counter_seq_remain #(.W(W)) u_remain (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .load_value (cmd_data),
    .dec        (rem_dec),
    .is_zero    (rem_zero),
    .is_one     (rem_one)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (op_e'(cmd_op))
              OP_LOAD: begin
                op_data <= cmd_data;
                state   <= ST_LOAD;
              end
              OP_CLEAR: begin
                op_data <= '0;
                state   <= ST_LOAD;
              end
              OP_RUN_N: begin
                op_data <= cmd_data;
                state   <= ST_RUN_N;
              end
              default: begin
                op_data <= cmd_data;
                state   <= ST_RUN_TO;
              end
            endcase
          end
        end
        ST_LOAD: state <= ST_DONE;
        ST_RUN_N: begin
          // Leave on the edge that issues the last enable, or at once for N=0.
          if (abort_w || rem_zero || (rem_one && !hold)) begin
            state <= ST_DONE;
          end
        end
        ST_RUN_TO: begin
          if (abort_w || at_target) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef COUNTER_SEQ_ABORT_EN
  logic aborted_q;

  // Remembers that the running command ended by abort; cleared on each accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aborted_q <= 1'b0;
    end else if (accept) begin
      aborted_q <= 1'b0;
    end else if (abort_w && ((state == ST_RUN_N) || (state == ST_RUN_TO))) begin
      aborted_q <= 1'b1;
    end
  end

  assign aborted = (state == ST_DONE) && aborted_q;
`endif

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign cnt_load  = (state == ST_LOAD);
  assign cnt_data  = (state == ST_LOAD) ? op_data : '0;

  always_comb begin
    cnt_enable = 1'b0;
    case (state)
      ST_RUN_N:  cnt_enable = !hold && !rem_zero && !abort_w;
      ST_RUN_TO: cnt_enable = !hold && !at_target && !abort_w;
      default:   cnt_enable = 1'b0;
    endcase
  end

endmodule
